gpio_bidir_bank: RTL and testbench

- Parametrised bank of WIDTH bidirectional GPIO pins behind a simple single-cycle register port.
- Provides per-pin output data and output enable, a synchronised input path, and per-pin rising/falling edge interrupts with sticky write-1-to-clear status.
- The pad tristate itself stays at the top level; this block drives pad_o/pad_oe and samples pad_i.

---
 rtl/gpio_pkg.sv | 16 +
 rtl/gpio_sync_edge.sv | 34 +++
 rtl/gpio_bidir_bank.sv | 91 +++++++++
 tb/tb_gpio_bidir_bank.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO bank: register indices, address width and pin limit.
package gpio_pkg;

   localparam int unsigned GPIO_ADDR_W    = 3;
   localparam int unsigned GPIO_MAX_WIDTH = 32;

   localparam logic [GPIO_ADDR_W-1:0] GPIO_DATA_IN  = 3'd0;
   localparam logic [GPIO_ADDR_W-1:0] GPIO_DATA_OUT = 3'd1;
   localparam logic [GPIO_ADDR_W-1:0] GPIO_OE       = 3'd2;
   localparam logic [GPIO_ADDR_W-1:0] GPIO_RISE_EN  = 3'd3;
   localparam logic [GPIO_ADDR_W-1:0] GPIO_FALL_EN  = 3'd4;
   localparam logic [GPIO_ADDR_W-1:0] GPIO_STATUS   = 3'd5;
   localparam logic [GPIO_ADDR_W-1:0] GPIO_OUT_SET  = 3'd6;
   localparam logic [GPIO_ADDR_W-1:0] GPIO_OUT_CLR  = 3'd7;

endpackage

// File: rtl/gpio_sync_edge.sv
// Vector input synchroniser with a previous-sample register for edge detection.
module gpio_sync_edge
   import gpio_pkg::*;
#(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] pad_i,
   output logic [WIDTH-1:0] sync,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall
);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
   logic [WIDTH-1:0]                  prev_q;

   // Stage 0 takes the raw pad; the last stage is the synchronised value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign sync = sync_q[SYNC_STAGES-1];
   assign rise = sync & ~prev_q;
   assign fall = ~sync & prev_q;

endmodule

// File: rtl/gpio_bidir_bank.sv
// Bank of bidirectional GPIO pins with a single-cycle register port and sticky edge interrupts.
module gpio_bidir_bank
   import gpio_pkg::*;
#(
   parameter int unsigned      WIDTH       = 32,
   parameter int unsigned      SYNC_STAGES = 2,
   parameter logic [WIDTH-1:0] RESET_OUT   = '0,
   parameter logic [WIDTH-1:0] RESET_OE    = '0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req_i,
   input  logic                   we_i,
   input  logic [GPIO_ADDR_W-1:0] addr_i,
   input  logic [WIDTH-1:0]       wdata_i,
   output logic [WIDTH-1:0]       rdata_o,
   output logic                   ack_o,
   input  logic [WIDTH-1:0]       pad_i,
   output logic [WIDTH-1:0]       pad_o,
   output logic [WIDTH-1:0]       pad_oe,
   output logic                   irq_o
);

   logic [WIDTH-1:0] out_q, oe_q, rise_en_q, fall_en_q, status_q;
   logic [WIDTH-1:0] sync, rise, fall;
   logic [WIDTH-1:0] rd_data_c, w1c_c;
   logic             wr_c;

   gpio_sync_edge #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .pad_i (pad_i),
      .sync  (sync),
      .rise  (rise),
      .fall  (fall)
   );

   assign wr_c  = req_i & we_i;
   assign w1c_c = (wr_c && addr_i == GPIO_STATUS) ? wdata_i : '0;

   // Read mux; write-only indices read as zero.
   always_comb begin
      rd_data_c = '0;
      case (addr_i)
         GPIO_DATA_IN:  rd_data_c = sync;
         GPIO_DATA_OUT: rd_data_c = out_q;
         GPIO_OE:       rd_data_c = oe_q;
         GPIO_RISE_EN:  rd_data_c = rise_en_q;
         GPIO_FALL_EN:  rd_data_c = fall_en_q;
         GPIO_STATUS:   rd_data_c = status_q;
         default:       rd_data_c = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q     <= RESET_OUT;
         oe_q      <= RESET_OE;
         rise_en_q <= '0;
         fall_en_q <= '0;
         status_q  <= '0;
         rdata_o   <= '0;
         ack_o     <= 1'b0;
         irq_o     <= 1'b0;
      end else begin
         ack_o    <= req_i;
         rdata_o  <= (req_i && !we_i) ? rd_data_c : '0;
         irq_o    <= |status_q;
         // A new edge outranks a simultaneous clear.
         status_q <= (status_q & ~w1c_c) | (rise & rise_en_q) | (fall & fall_en_q);
         if (wr_c) begin
            case (addr_i)
               GPIO_DATA_OUT: out_q     <= wdata_i;
               GPIO_OE:       oe_q      <= wdata_i;
               GPIO_RISE_EN:  rise_en_q <= wdata_i;
               GPIO_FALL_EN:  fall_en_q <= wdata_i;
               GPIO_OUT_SET:  out_q     <= out_q | wdata_i;
               GPIO_OUT_CLR:  out_q     <= out_q & ~wdata_i;
               default: ;
            endcase
         end
      end
   end

   assign pad_o  = out_q;
   assign pad_oe = oe_q;

endmodule

// File: tb/tb_gpio_bidir_bank.sv
// Self-checking bench for gpio_bidir_bank: directed scenarios plus random traffic against a reference model.
module tb_gpio_bidir_bank;

   localparam int unsigned W = 8;
   localparam int unsigned S = 2;
   localparam logic [W-1:0] R_OUT = 8'hA5;
   localparam logic [W-1:0] R_OE  = 8'h0F;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         req = 1'b0;
   logic         we = 1'b0;
   logic [2:0]   addr = '0;
   logic [W-1:0] wdata = '0;
   logic [W-1:0] pad = '0;
   logic [W-1:0] rdata, pad_o, pad_oe;
   logic         ack, irq;

   int total = 0;
   int bad = 0;

   // Reference model state
   logic [W-1:0] m_out, m_oe, m_ren, m_fen, m_stat, m_rdata;
   logic         m_ack, m_irq;
   logic [W-1:0] hist[$];   // hist[0] = pad sampled at the latest edge

   gpio_bidir_bank #(
      .WIDTH       (W),
      .SYNC_STAGES (S),
      .RESET_OUT   (R_OUT),
      .RESET_OE    (R_OE)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req_i   (req),
      .we_i    (we),
      .addr_i  (addr),
      .wdata_i (wdata),
      .rdata_o (rdata),
      .ack_o   (ack),
      .pad_i   (pad),
      .pad_o   (pad_o),
      .pad_oe  (pad_oe),
      .irq_o   (irq)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_out = R_OUT; m_oe = R_OE; m_ren = '0; m_fen = '0; m_stat = '0;
      m_rdata = '0; m_ack = 1'b0; m_irq = 1'b0;
      hist.delete();
      for (int i = 0; i <= S; i++) hist.push_back('0);
   endtask

   // Advance the model across one rising edge using the inputs currently applied.
   task automatic model_edge();
      logic [W-1:0] sy, pv, ri, fa, clr;
      sy = hist[S-1];
      pv = hist[S];
      ri = sy & ~pv;
      fa = ~sy & pv;
      m_ack = req;
      m_rdata = '0;
      if (req && !we) begin
         case (addr)
            3'd0: m_rdata = sy;
            3'd1: m_rdata = m_out;
            3'd2: m_rdata = m_oe;
            3'd3: m_rdata = m_ren;
            3'd4: m_rdata = m_fen;
            3'd5: m_rdata = m_stat;
            default: m_rdata = '0;
         endcase
      end
      clr = (req && we && addr == 3'd5) ? wdata : '0;
      m_irq = (m_stat != '0);
      m_stat = (m_stat & ~clr) | (ri & m_ren) | (fa & m_fen);
      if (req && we) begin
         case (addr)
            3'd1: m_out = wdata;
            3'd2: m_oe = wdata;
            3'd3: m_ren = wdata;
            3'd4: m_fen = wdata;
            3'd6: m_out = m_out | wdata;
            3'd7: m_out = m_out & ~wdata;
            default: ;
         endcase
      end
      hist.push_front(pad);
      void'(hist.pop_back());
   endtask

   task automatic step(input logic r, input logic w, input logic [2:0] a,
                       input logic [W-1:0] d, input logic [W-1:0] p);
      @(negedge clk);
      req = r; we = w; addr = a; wdata = d; pad = p;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [W-1:0] d);
      step(1'b1, 1'b1, a, d, pad);
   endtask

   task automatic rd(input logic [2:0] a);
      step(1'b1, 1'b0, a, '0, pad);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, '0, pad);
   endtask

   task automatic release_reset();
      @(negedge clk);
      req = 1'b0; we = 1'b0;
      rst_n = 1'b1;
      model_reset();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      logic [W-1:0] exp_rd[8];
      exp_rd = '{8'h00, 8'hA5, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      total++; if (pad_o !== R_OUT) begin bad++; $display("FAIL rst_pad_o got=%h exp=%h", pad_o, R_OUT); end
      total++; if (pad_oe !== R_OE) begin bad++; $display("FAIL rst_pad_oe got=%h exp=%h", pad_oe, R_OE); end
      total++; if (ack !== 1'b0 || irq !== 1'b0 || rdata !== '0) begin
         bad++; $display("FAIL rst_outputs ack=%b irq=%b rdata=%h exp=0/0/00", ack, irq, rdata);
      end
      release_reset();
      for (int i = 0; i < 8; i++) begin
         rd(3'(i));
         total++; if (ack !== 1'b1) begin bad++; $display("FAIL rst_read_ack idx=%0d got=%b exp=1", i, ack); end
         total++; if (rdata !== exp_rd[i]) begin bad++; $display("FAIL rst_read idx=%0d got=%h exp=%h", i, rdata, exp_rd[i]); end
      end
      idle(1);
      total++; if (ack !== 1'b0 || rdata !== '0) begin
         bad++; $display("FAIL rst_ack_drop ack=%b rdata=%h exp=0/00", ack, rdata);
      end
   endtask

   task automatic test_data_out();
      logic [W-1:0] exp_v[3];
      logic [2:0]   ops[3];
      logic [W-1:0] vals[3];
      exp_v = '{8'h3C, 8'hBD, 8'hB1};
      ops   = '{3'd1, 3'd6, 3'd7};
      vals  = '{8'h3C, 8'h81, 8'h0C};
      for (int i = 0; i < 3; i++) begin
         wr(ops[i], vals[i]);
         total++; if (ack !== 1'b1 || rdata !== '0) begin
            bad++; $display("FAIL dout_wr_ack op=%0d ack=%b rdata=%h exp=1/00", i, ack, rdata);
         end
         total++; if (pad_o !== exp_v[i]) begin bad++; $display("FAIL dout_pad op=%0d got=%h exp=%h", i, pad_o, exp_v[i]); end
         rd(3'd1);
         total++; if (rdata !== exp_v[i]) begin bad++; $display("FAIL dout_read op=%0d got=%h exp=%h", i, rdata, exp_v[i]); end
      end
      rd(3'd6);
      total++; if (rdata !== '0) begin bad++; $display("FAIL out_set_read got=%h exp=00", rdata); end
   endtask

   task automatic test_status();
      wr(3'd3, 8'h01);
      wr(3'd4, 8'h02);
      step(1'b0, 1'b0, 3'd0, '0, 8'h02);
      idle(S + 2);
      rd(3'd5);
      total++; if (rdata !== 8'h00) begin bad++; $display("FAIL stat_pre got=%h exp=00", rdata); end
      step(1'b0, 1'b0, 3'd0, '0, 8'h03);
      idle(S);
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL stat_irq_lag got=%b exp=0", irq); end
      rd(3'd5);
      total++; if (rdata !== 8'h01) begin bad++; $display("FAIL stat_rise got=%h exp=01", rdata); end
      total++; if (irq !== 1'b1) begin bad++; $display("FAIL stat_irq_set got=%b exp=1", irq); end
      step(1'b0, 1'b0, 3'd0, '0, 8'h01);
      idle(S + 1);
      rd(3'd5);
      total++; if (rdata !== 8'h03) begin bad++; $display("FAIL stat_fall got=%h exp=03", rdata); end
      wr(3'd5, 8'h01);
      rd(3'd5);
      total++; if (rdata !== 8'h02) begin bad++; $display("FAIL stat_w1c got=%h exp=02", rdata); end
      total++; if (irq !== 1'b1) begin bad++; $display("FAIL stat_irq_hold got=%b exp=1", irq); end
   endtask

   task automatic test_set_wins();
      step(1'b0, 1'b0, 3'd0, '0, 8'h00);
      idle(S + 1);
      step(1'b0, 1'b0, 3'd0, '0, 8'h01);
      idle(S - 1);
      wr(3'd5, 8'h01);
      rd(3'd5);
      total++; if (rdata !== 8'h03) begin bad++; $display("FAIL set_wins got=%h exp=03", rdata); end
      total++; if (irq !== 1'b1) begin bad++; $display("FAIL set_wins_irq got=%b exp=1", irq); end
   endtask

   task automatic test_no_retro();
      wr(3'd5, 8'hFF);
      idle(2);
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL clear_all_irq got=%b exp=0", irq); end
      step(1'b0, 1'b0, 3'd0, '0, 8'h05);
      idle(S + 1);
      wr(3'd3, 8'h05);
      idle(2);
      rd(3'd5);
      total++; if (rdata !== 8'h00) begin bad++; $display("FAIL no_retro got=%h exp=00", rdata); end
      step(1'b0, 1'b0, 3'd0, '0, 8'h01);
      idle(S + 1);
      step(1'b0, 1'b0, 3'd0, '0, 8'h05);
      idle(S + 1);
      rd(3'd5);
      total++; if (rdata !== 8'h04) begin bad++; $display("FAIL new_rise got=%h exp=04", rdata); end
   endtask

   task automatic test_reset_mid();
      // Write pending at the edge when reset asserts
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = 3'd1; wdata = 8'hFF;
      #2 rst_n = 1'b0;
      #1;
      total++; if (pad_o !== R_OUT || pad_oe !== R_OE) begin
         bad++; $display("FAIL mid_async_pad pad_o=%h pad_oe=%h exp=%h/%h", pad_o, pad_oe, R_OUT, R_OE);
      end
      total++; if (ack !== 1'b0 || irq !== 1'b0 || rdata !== '0) begin
         bad++; $display("FAIL mid_async_out ack=%b irq=%b rdata=%h exp=0/0/00", ack, irq, rdata);
      end
      @(posedge clk);
      #1;
      total++; if (pad_o !== R_OUT) begin bad++; $display("FAIL mid_no_write got=%h exp=%h", pad_o, R_OUT); end
      release_reset();
      rd(3'd1);
      total++; if (rdata !== R_OUT) begin bad++; $display("FAIL mid_dout got=%h exp=%h", rdata, R_OUT); end
      rd(3'd5);
      total++; if (rdata !== 8'h00) begin bad++; $display("FAIL mid_status got=%h exp=00", rdata); end
      // Ack already high when reset asserts
      rd(3'd2);
      #2 rst_n = 1'b0;
      #1;
      total++; if (ack !== 1'b0 || rdata !== '0) begin
         bad++; $display("FAIL mid_ack_drop ack=%b rdata=%h exp=0/00", ack, rdata);
      end
      release_reset();
   endtask

   task automatic test_random();
      logic [W-1:0] p;
      p = pad;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) p = p ^ W'($urandom);
         step($urandom_range(0, 3) != 0, 1'($urandom), 3'($urandom), W'($urandom), p);
         total++; if (ack !== m_ack) begin bad++; $display("FAIL rnd_ack cyc=%0d got=%b exp=%b", i, ack, m_ack); end
         total++; if (rdata !== m_rdata) begin bad++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", i, rdata, m_rdata); end
         total++; if (pad_o !== m_out) begin bad++; $display("FAIL rnd_pad_o cyc=%0d got=%h exp=%h", i, pad_o, m_out); end
         total++; if (pad_oe !== m_oe) begin bad++; $display("FAIL rnd_pad_oe cyc=%0d got=%h exp=%h", i, pad_oe, m_oe); end
         total++; if (irq !== m_irq) begin bad++; $display("FAIL rnd_irq cyc=%0d got=%b exp=%b", i, irq, m_irq); end
      end
   endtask

   initial begin
      test_reset();
      test_data_out();
      test_status();
      test_set_wins();
      test_no_retro();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
